data_sram_resp: RTL
===================

Name: data_sram_resp

Overview:
- Responder end of the CPU data_sram port: the memory side that answers the pipeline MEM stage's en/wen/addr/wdata requests with rdata.
- Contains a word-organised synchronous RAM with byte-lane writes and one-cycle read latency.
- Contains a small memory-mapped register window (LED, switch, optional timer).
- Also drives a registered debug read port for the display/test harness.
- Sits beside mycpu_top in the SoC top, replacing the IP data RAM.

Parameters:
- DEPTH, 256: number of 32-bit RAM words; word index = addr[log2(DEPTH)+1:2].
- MMIO_BASE, 32'hBFAF_0000: base address of the register window; match on addr[31:16].
- RAM_BASE, 32'h0000_0000: base of the RAM region; match on addr[31:16].

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous reset, active-high.
- data_sram_en  in  1  request valid this cycle.
- data_sram_wen  in  4  byte write enables, bit i enables wdata[8i+7:8i]; 0 = read.
- data_sram_addr  in  32  byte address; bits [1:0] ignored.
- data_sram_wdata  in  32  write data.
- data_sram_rdata  out  32  read data, registered.
- switch_in  in  8  board switches, sampled by the SWITCH register.
- led_out  out  16  LED register value.
- mem_addr  in  32  debug read address.
- mem_data  out  32  debug read data, registered, RAM region only.

Behaviour:
- Reset values: data_sram_rdata=0, mem_data=0, led_out=0, timer=0. RAM contents are not cleared.
- Region decode, in this order:
  - addr[31:16]==MMIO_BASE[31:16]: MMIO access.
  - addr[31:16]==RAM_BASE[31:16] and word index < DEPTH: RAM access.
  - Anything else: unmapped.
- RAM read (en=1, wen=0): rdata on the following posedge holds the word at that index. Latency is exactly 1 cycle, matching the CPU's synchronous-read assumption.
- RAM write (en=1, wen!=0):
  - Only enabled bytes are updated at the posedge.
  - Same cycle's rdata is read-first: it captures the pre-write word.
  - A read of the same address in the next cycle returns the merged word.
- en=0: no write; rdata holds its previous value.
- Unmapped access:
  - Writes are dropped.
  - Reads load rdata=0.
  - Out-of-range indices never alias or wrap into the RAM.
- MMIO offsets, from addr[15:0]:
  - 0x0000 LED: R/W. Byte-enable write to bits [15:0]; bytes 2–3 ignored. Reads return {16'd0, led}.
  - 0x0004 SWITCH: read-only. Reads return {24'd0, switch_in} sampled at the read posedge. Writes ignored.
  - 0x0008 TIMER: see Optional Feature.
  - Other offsets: read 0, writes ignored.
- MMIO reads are also 1-cycle registered. A write to any MMIO register returns its pre-write value on rdata (read-first).
- Back-to-back requests are accepted every cycle. There is no stall or ready signal; the block never back-pressures.
- Debug port: each cycle mem_data <= RAM word at mem_addr index, or 0 if out of range/non-RAM. Independent of the CPU port. If both hit the same word in the same cycle as a CPU write, mem_data shows the pre-write word.
- Reset asserted mid-stream:
  - Any write in the reset cycle is suppressed, for both RAM and registers.
  - rdata is forced to 0.
  - The first request after reset deasserts is serviced normally.

Optional Feature:
- Macro DATA_SRAM_TIMER_EN.
- Defined:
  - TIMER is a 32-bit free-running counter, +1 every cycle out of reset, wrapping 0xFFFF_FFFF->0.
  - Byte-enable writes load the enabled bytes. The write wins over the increment in that cycle; counting resumes from the written value next cycle.
  - Reads return the value before that cycle's update.
- Undefined: no counter logic; offset 0x0008 reads 0 and writes are ignored.

Test Plan:
- Write 0x12345678 wen=4'hF to 0x00000010, then read 0x10 -> rdata=0x12345678 exactly one cycle after the read request.
- Write 0xAABBCCDD wen=4'b0101 over 0x12345678 at 0x10, then read -> 0x12BB56DD. The write cycle's own rdata = 0x12345678.
- Read/write address 0x00000400 with DEPTH=256 -> write dropped; read rdata=0; word 0 unchanged.
- Write LED 0x0000BEEF wen=4'hF at 0xBFAF0000 -> led_out=0xBEEF next cycle. With switch_in=0x5A, read 0xBFAF0004 -> rdata=0x0000005A.
- With DATA_SRAM_TIMER_EN:
  - Write 0xFFFFFFFE to TIMER -> reads one and two cycles later return 0xFFFFFFFE and 0xFFFFFFFF, then wrap to 0.
  - Without the macro -> TIMER reads 0.
- Assert reset during a write of 0x55 to LED -> led_out stays 0 and rdata=0. The first read after deassert returns the correct RAM data.

Source files
------------

// File: rtl/data_sram_resp.sv
// data_sram_resp: responder for the CPU data_sram port.
// Holds a word-organised synchronous RAM with byte-lane writes, a small MMIO
// register window (LED, SWITCH, optional TIMER), and a registered debug read port.
// Optional feature macro: DATA_SRAM_TIMER_EN adds a free-running 32-bit TIMER at offset 0x0008.
// Ports:
//   clk, reset            - clock; synchronous active-high reset
//   data_sram_en/wen      - request valid; byte write enables (0 = read)
//   data_sram_addr/wdata  - byte address (bits [1:0] ignored); write data
//   data_sram_rdata       - registered read data, one-cycle latency, read-first
//   switch_in / led_out   - board switches in; LED register out
//   mem_addr / mem_data   - debug read address; registered debug data (RAM region only)
module data_sram_resp #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000,
    parameter logic [31:0] RAM_BASE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led_out,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_data
);

    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] OFF_LED   = 16'h0000;
    localparam logic [15:0] OFF_SW    = 16'h0004;
    localparam logic [15:0] OFF_TIMER = 16'h0008;

    logic [31:0]      ram [DEPTH];
    logic             cpu_mmio;
    logic             cpu_ram;
    logic             dbg_ram;
    logic [IDX_W-1:0] cpu_idx;
    logic [IDX_W-1:0] dbg_idx;
    logic             ram_we;
    logic             mmio_acc;
    logic [31:0]      mmio_rdata;
    logic             unused_bits;

    // Region decode: MMIO wins; RAM requires the full word index to be in range so nothing aliases.
    assign cpu_mmio = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
    assign cpu_ram  = !cpu_mmio && (data_sram_addr[31:16] == RAM_BASE[31:16])
                      && (32'(data_sram_addr[15:2]) < DEPTH);
    assign dbg_ram  = (mem_addr[31:16] != MMIO_BASE[31:16]) && (mem_addr[31:16] == RAM_BASE[31:16])
                      && (32'(mem_addr[15:2]) < DEPTH);
    assign cpu_idx  = data_sram_addr[IDX_W+1:2];
    assign dbg_idx  = mem_addr[IDX_W+1:2];

    assign ram_we   = !reset && data_sram_en && cpu_ram && (data_sram_wen != 4'd0);
    assign mmio_acc = !reset && data_sram_en && cpu_mmio;

    assign unused_bits = ^{data_sram_addr[1:0], mem_addr[1:0]};

    // RAM byte-lane write; contents are not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wen[b]) begin
                    ram[cpu_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    // LED register: only the low two byte lanes exist.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_out <= 16'd0;
        end else if (mmio_acc && (data_sram_addr[15:0] == OFF_LED)) begin
            if (data_sram_wen[0]) led_out[7:0]  <= data_sram_wdata[7:0];
            if (data_sram_wen[1]) led_out[15:8] <= data_sram_wdata[15:8];
        end
    end

`ifdef DATA_SRAM_TIMER_EN
    logic [31:0] timer_q;
    logic [31:0] timer_next;

    // Free-running counter; a byte write replaces the increment for that cycle.
    always_comb begin
        timer_next = timer_q + 32'd1;
        if (mmio_acc && (data_sram_addr[15:0] == OFF_TIMER) && (data_sram_wen != 4'd0)) begin
            timer_next = timer_q;
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wen[b]) timer_next[8*b +: 8] = data_sram_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) timer_q <= 32'd0;
        else       timer_q <= timer_next;
    end
`endif

    // MMIO read mux sees pre-update register values, giving read-first behaviour.
    always_comb begin
        mmio_rdata = 32'd0;
        case (data_sram_addr[15:0])
            OFF_LED:   mmio_rdata = {16'd0, led_out};
            OFF_SW:    mmio_rdata = {24'd0, switch_in};
`ifdef DATA_SRAM_TIMER_EN
            OFF_TIMER: mmio_rdata = timer_q;
`endif
            default:   mmio_rdata = 32'd0;
        endcase
    end

    // CPU read data: holds when idle, zero for unmapped accesses.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_sram_rdata <= 32'd0;
        end else if (data_sram_en) begin
            if (cpu_mmio)     data_sram_rdata <= mmio_rdata;
            else if (cpu_ram) data_sram_rdata <= ram[cpu_idx];
            else              data_sram_rdata <= 32'd0;
        end
    end

    // Debug read port, independent of the CPU port; shows pre-write data on a collision.
    always_ff @(posedge clk) begin
        if (reset)        mem_data <= 32'd0;
        else if (dbg_ram) mem_data <= ram[dbg_idx];
        else              mem_data <= 32'd0;
    end

endmodule
